// File: rtl/shift_reg_ctrl.sv
// Command-driven shift register: LOAD, shift left/right, or rotate left by a
// latched step count, with a ready/valid command port and a one-cycle done pulse.
module shift_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             o_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             run_q, run_d;
  logic             accept;

  // run_q keeps o_ready low until the first edge after reset is released.
  assign o_ready = (state_q == S_IDLE) && run_q;
  assign o_busy  = (state_q == S_EXEC) || (state_q == S_DONE);
  assign o_done  = (state_q == S_DONE);
  assign o_q     = q_q;
  assign o_sout  = sout_q;
  assign accept  = in_valid && o_ready;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    data_d  = data_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    run_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = in_op;
          data_d = in_data;
          cnt_d  = in_cnt;
          // A zero-step shift completes without touching the register.
          if ((in_op != OP_LOAD) && (in_cnt == '0)) state_d = S_DONE;
          else                                      state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD: begin
            q_d     = data_q;
            state_d = S_DONE;
          end
          OP_SHL: begin
            q_d    = {q_q[WIDTH-2:0], in_sin};
            sout_d = q_q[WIDTH-1];
          end
          OP_SHR: begin
            q_d    = {in_sin, q_q[WIDTH-1:1]};
            sout_d = q_q[0];
          end
          OP_ROL: begin
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            sout_d = q_q[WIDTH-1];
          end
          default: state_d = S_DONE;
        endcase
        if (op_q != OP_LOAD) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl: a cycle-countdown reference model checked
// every cycle, plus literal expectations for the worked command scenarios.
module tb_shift_reg_ctrl;
  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  data = '0;
  logic [CW-1:0] cnt = '0;
  logic          sin = 1'b0;
  logic          ready, sout, busy, done;
  logic [W-1:0]  q;

  int n_pass = 0;
  int n_total = 0;

  shift_reg_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid), .o_ready(ready),
    .in_op(op), .in_data(data), .in_cnt(cnt), .in_sin(sin),
    .o_q(q), .o_sout(sout), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a command occupies a number of cycles until ready returns,
  // and applies one arithmetic step per cycle while steps remain.
  int       busy_left = 0;
  int       steps_left = 0;
  bit       load_pend = 0;
  bit       m_run = 0;
  int       m_op = 0;
  int       m_data = 0;
  int       m_q = 0;
  int       m_sout = 0;
  localparam int MASK = (1 << W) - 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      busy_left = 0; steps_left = 0; load_pend = 0; m_run = 0; m_q = 0; m_sout = 0;
    end else begin
      if (busy_left > 0) begin
        if (steps_left > 0) begin
          case (m_op)
            1: begin m_sout = (m_q >> (W-1)) & 1; m_q = ((m_q << 1) | int'(sin)) & MASK; end
            2: begin m_sout = m_q & 1; m_q = (m_q >> 1) | (int'(sin) << (W-1)); end
            default: begin m_sout = (m_q >> (W-1)) & 1; m_q = ((m_q << 1) | (m_q >> (W-1))) & MASK; end
          endcase
          steps_left--;
        end else if (load_pend) begin
          m_q = m_data; load_pend = 0;
        end
        busy_left--;
      end else if (m_run && valid) begin
        m_op = int'(op); m_data = int'(data);
        if (op == 2'b00) begin load_pend = 1; busy_left = 2; end
        else if (cnt == 0) busy_left = 1;
        else begin steps_left = int'(cnt); busy_left = int'(cnt) + 1; end
      end
      m_run = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_sout", 32'(sout), 32'(m_sout));
    chk("model_busy", 32'(busy), 32'(busy_left > 0));
    chk("model_done", 32'(done), 32'(busy_left == 1));
    chk("model_ready", 32'(ready), 32'(m_run && busy_left == 0));
  end

  // Drives a single-cycle command; returns at the negedge after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] d, input logic [CW-1:0] c);
    @(negedge clk);
    valid = 1'b1; op = o; data = d; cnt = c;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      if (ready) return;
      @(negedge clk);
    end
    chk("ready_timeout", 32'(ready), 32'(1));
  endtask

  initial begin
    int busy_cnt;
    logic [W-1:0] rol_seq [5];
    rol_seq[0] = 4'b0001; rol_seq[1] = 4'b0010; rol_seq[2] = 4'b0100;
    rol_seq[3] = 4'b1000; rol_seq[4] = 4'b0001;

    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 32'(1));

    // LOAD 1011
    issue(2'b00, 4'b1011, 3'd0);
    chk("load_busy", 32'(busy), 32'(1));
    chk("load_q_before", 32'(q), 32'(0));
    @(negedge clk);
    chk("load_q", 32'(q), 32'(4'b1011));
    chk("load_done", 32'(done), 32'(1));
    @(negedge clk);
    chk("load_ready_back", 32'(ready), 32'(1));
    chk("load_done_off", 32'(done), 32'(0));

    // SHL 2 with sin 1 then 0
    sin = 1'b1;
    issue(2'b01, 4'b0000, 3'd2);
    @(negedge clk);
    chk("shl_q1", 32'(q), 32'(4'b0111));
    chk("shl_sout1", 32'(sout), 32'(1));
    chk("shl_done1", 32'(done), 32'(0));
    sin = 1'b0;
    @(negedge clk);
    chk("shl_q2", 32'(q), 32'(4'b1110));
    chk("shl_sout2", 32'(sout), 32'(0));
    chk("shl_done2", 32'(done), 32'(1));
    @(negedge clk);
    wait_ready();

    // ROL 5 from 1000
    issue(2'b00, 4'b1000, 3'd0);
    @(negedge clk);
    @(negedge clk);
    wait_ready();
    sin = 1'b1;
    issue(2'b11, 4'b0000, 3'd5);
    busy_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rol_step", 32'(q), 32'(rol_seq[i]));
      if (busy) busy_cnt++;
    end
    chk("rol_done", 32'(done), 32'(1));
    @(negedge clk);
    if (busy) busy_cnt++;
    chk("rol_busy_cycles", 32'(busy_cnt), 32'(6));
    chk("rol_ready", 32'(ready), 32'(1));

    // SHR 0 on 0110
    issue(2'b00, 4'b0110, 3'd0);
    @(negedge clk);
    @(negedge clk);
    issue(2'b10, 4'b0000, 3'd0);
    chk("shr0_done", 32'(done), 32'(1));
    chk("shr0_q", 32'(q), 32'(4'b0110));
    @(negedge clk);
    chk("shr0_ready", 32'(ready), 32'(1));
    chk("shr0_q_hold", 32'(q), 32'(4'b0110));

    // SHR 3 with valid held and a LOAD left on the bus
    sin = 1'b1;
    valid = 1'b1; op = 2'b10; cnt = 3'd3; data = 4'b0000;
    @(negedge clk);
    op = 2'b00; data = 4'b1010; cnt = 3'd0;
    @(negedge clk);
    chk("hold_q1", 32'(q), 32'(4'b1011));
    @(negedge clk);
    chk("hold_q2", 32'(q), 32'(4'b1101));
    @(negedge clk);
    chk("hold_q3", 32'(q), 32'(4'b1110));
    chk("hold_sout3", 32'(sout), 32'(1));
    chk("hold_done", 32'(done), 32'(1));
    @(negedge clk);
    chk("hold_ready", 32'(ready), 32'(1));
    chk("hold_q_idle", 32'(q), 32'(4'b1110));
    @(negedge clk);
    valid = 1'b0;
    chk("hold_accept_busy", 32'(busy), 32'(1));
    chk("hold_q_acc", 32'(q), 32'(4'b1110));
    @(negedge clk);
    chk("hold_load_q", 32'(q), 32'(4'b1010));
    @(negedge clk);
    wait_ready();

    // Reset during second step of SHL 4, with a command pending on the bus
    issue(2'b01, 4'b0000, 3'd4);
    @(negedge clk);
    chk("abort_q1", 32'(q), 32'(4'b0101));
    rst_n = 1'b0;
    valid = 1'b1; op = 2'b00; data = 4'b1111;
    @(negedge clk);
    chk("abort_q", 32'(q), 32'(0));
    chk("abort_sout", 32'(sout), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'(1));

    // SHR 7 (more steps than bits), sin alternates through the model
    issue(2'b00, 4'b1001, 3'd0);
    @(negedge clk);
    @(negedge clk);
    wait_ready();
    sin = 1'b0;
    issue(2'b10, 4'b0000, 3'd7);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sin = ~sin;
    end
    chk("shr7_done", 32'(done), 32'(1));
    chk("shr7_q", 32'(q), 32'(4'b0101));
    @(negedge clk);
    wait_ready();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
